// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV64 writeback types and load funct3 encodings
//
// Purpose: common definitions for the writeback stage and load extension.
// Contents: XLEN, RV64I load funct3 constants, wb_entry_t (rd + data).

package rv_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - byte-lane select and sign/zero extension of load data
//
// Purpose: purely combinational map (funct3, off, raw) -> extended load value.
// Ports:
//   funct3 - RV64I load type
//   off    - byte offset within the doubleword (address[2:0])
//   raw    - aligned doubleword from memory
//   data   - selected and extended result

module load_extend
    import rv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      off,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data
);

    logic [2:0]      lane_off;
    logic [XLEN-1:0] shifted;

    always_comb begin
        lane_off = 3'b000;
        data     = '0;

        // Offset bits below the access size are dropped: misaligned
        // accesses are silently truncated to the containing lane.
        case (funct3)
            F3_LB, F3_LBU: lane_off = off;
            F3_LH, F3_LHU: lane_off = {off[2:1], 1'b0};
            F3_LW, F3_LWU: lane_off = {off[2], 2'b00};
            default:       lane_off = 3'b000;
        endcase

        shifted = raw >> {lane_off, 3'b000};

        case (funct3)
            F3_LB:   data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_LBU:  data = {{(XLEN-8){1'b0}},         shifted[7:0]};
            F3_LHU:  data = {{(XLEN-16){1'b0}},        shifted[15:0]};
            F3_LWU:  data = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: data = shifted;   // LD and the unused 111 encoding
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage merging ALU and load results onto the regfile write port
//
// Purpose: arbitrates ALU results and extended load results (held in a small
// FIFO) onto the single register-file write port; exports pending load dests.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data         - ALU result in, alu_ready accepts it
//   ld_valid/ld_rd/ld_funct3/ld_off/ld_data - load return in, ld_ready accepts it
//   RegWrite/Write_register/Write_data - register-file write port
//   busy                              - onehot OR of queued load destinations

module wb_stage
    import rv_pkg::*;
#(
    parameter int XLEN     = rv_pkg::XLEN,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [2:0]      ld_off,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    output logic            RegWrite,
    output logic [4:0]      Write_register,
    output logic [XLEN-1:0] Write_data,
    output logic [31:0]     busy
);

    localparam int           PW      = $clog2(LQ_DEPTH);
    localparam logic [PW:0]  DEPTH_C = LQ_DEPTH[PW:0];

    wb_entry_t         lq_mem [LQ_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;

    logic [XLEN-1:0]   ld_ext;
    logic              push;
    logic              pop;
    wb_entry_t         head;

    load_extend u_load_extend (
        .funct3 (ld_funct3),
        .off    (ld_off),
        .raw    (ld_data),
        .data   (ld_ext)
    );

    // Readies depend only on registered occupancy, never on the valids.
    assign ld_ready  = (count != DEPTH_C);
    assign alu_ready = (count == '0);

    assign push = ld_valid && ld_ready;
    assign pop  = (count != '0);
    assign head = lq_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                lq_mem[wr_ptr] <= '{rd: ld_rd, data: ld_ext};
                wr_ptr         <= wr_ptr + 1'b1;   // power-of-two depth wraps naturally
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queued loads always win the port, so an ALU result can never overtake
    // a load; alu_ready already guarantees the FIFO is empty when ALU wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_data     <= '0;
        end else if (pop) begin
            RegWrite       <= (head.rd != 5'd0);
            Write_register <= head.rd;
            Write_data     <= head.data;
        end else if (alu_valid) begin
            RegWrite       <= (alu_rd != 5'd0);
            Write_register <= alu_rd;
            Write_data     <= alu_data;
        end else begin
            RegWrite       <= 1'b0;
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        busy = '0;
        idx  = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            idx = rd_ptr + i[PW-1:0];
            if (i[PW:0] < count) begin
                busy[lq_mem[idx].rd] = 1'b1;
            end
        end
        busy[0] = 1'b0;   // x0 is never a real hazard
    end

endmodule
